p_mac_fmt: RTL
==============

Name: p_mac_fmt

Overview:
AEAD MAC-data formatter that sits directly upstream of the Poly1305 tag engine. It fetches AAD and ciphertext 128-bit words from the data buffer and zero-pads each stream to a 16-byte boundary. It then appends the 16-byte lengths block and hands the resulting stream to the tag engine one block at a time, using the engine's start, request and enable handshake. Every block it emits is full, so the total length it reports is always a multiple of 16.

Parameters:
LEN_W, 64, width of the AAD and ciphertext byte-length inputs; fixed by RFC 8439.

Ports:
i_clk  in  1  clock, rising edge
i_rstn  in  1  asynchronous active-low reset
i_start  in  1  one-cycle pulse: begin a message; samples i_len_aad and i_len_ct
i_len_aad  in  LEN_W  AAD length in bytes; legal range 0..2^38
i_len_ct  in  LEN_W  ciphertext length in bytes; legal range 0..2^38
o_rqst_data  out  1  one-cycle pulse: request the next 128-bit word from the source
o_sel_ct  out  1  stream being fetched: 0 = AAD, 1 = ciphertext; stable from the o_rqst_data pulse until i_data_valid
i_data_valid  in  1  one-cycle pulse: i_data is valid
i_data  in  128  source word, little-endian; byte 0 is on bits [7:0]
i_rqst_msg  in  1  one-cycle pulse from the tag engine asking for the next block
o_start  out  1  one-cycle pulse carrying the first block; drives the tag engine's start input
o_en_msg  out  1  one-cycle pulse carrying every block after the first
o_msg  out  128  block payload; valid while o_start or o_en_msg is high
o_len_msg  out  65  total MAC length in bytes; valid from o_start until the next i_start
o_busy  out  1  high from the cycle after i_start until o_done
o_done  out  1  one-cycle pulse in the cycle after the lengths block is emitted

Behaviour:
- Reset (asynchronous, active-low): FSM goes to IDLE. Every output and internal register clears to 0.
- On i_start in IDLE, latch both lengths and compute:
  - na = ceil(len_aad/16) and nc = ceil(len_ct/16);
  - N = na + nc + 1;
  - o_len_msg = 16*N.
- i_start while o_busy is high is ignored.
- FSM states: IDLE, FETCH, WAIT_SRC, EMIT, WAIT_RQST, LENBLK, DONE.
- Block order: na AAD blocks, then nc ciphertext blocks, then one lengths block.
- Lengths block: o_msg = {len_ct[63:0], len_aad[63:0]}, with len_aad on [63:0].
- IDLE -> FETCH on i_start, or IDLE -> LENBLK on i_start when na = nc = 0.
- FETCH: pulse o_rqst_data for one cycle and set o_sel_ct (1 once the AAD count is exhausted). Then -> WAIT_SRC.
- WAIT_SRC: hold indefinitely until i_data_valid.
  - On i_data_valid, register the masked word -> EMIT.
  - If the word is the last of its stream and len mod 16 = r ≠ 0, zero bytes r..15.
- EMIT: drive o_msg for one cycle.
  - Pulse o_start if this is the first block of the message, otherwise pulse o_en_msg.
  - Then -> WAIT_RQST.
- WAIT_RQST: on i_rqst_msg (or a pending request) -> FETCH if data blocks remain, else -> LENBLK.
- LENBLK: drive the lengths block for one cycle.
  - Pulse o_start if it is the only block of the message, otherwise pulse o_en_msg.
  - Then -> DONE.
- DONE: pulse o_done for one cycle -> IDLE.
- Request latching: an i_rqst_msg pulse arriving in any non-IDLE state sets a pending flag. The flag is consumed on entry to WAIT_RQST. A second request while one is already pending is an engine protocol error and is dropped.
- Latency:
  - i_start to the first o_rqst_data: 1 cycle.
  - i_data_valid to o_start/o_en_msg: 1 cycle.
  - i_rqst_msg to o_rqst_data: 1 cycle from WAIT_RQST.
  - i_rqst_msg to the lengths-block o_en_msg: 1 cycle.
- Counter arithmetic:
  - Block counters are 35 bits, enough for 2^38/16 blocks.
  - o_len_msg is computed in 65 bits and never wraps within the legal length range.
- i_data_valid outside WAIT_SRC is ignored.

Test Plan:
1. RFC 8439 §2.8.2 vector: len_aad = 12, len_ct = 114 -> o_len_msg = 160 and 10 blocks emitted.
   - Block 0 (o_start): AAD with bytes 12..15 zero.
   - Block 8: bytes 2..15 zero.
   - Block 9: 128'h0000000000000072_000000000000000C.
   - Engine model's tag matches 1ae10b594f09e26a7e902ecbd0600691.
2. len_aad = 0, len_ct = 0 -> no o_rqst_data; o_start with a zero block; o_len_msg = 16; o_done 2 cycles after i_start.
3. len_aad = 16, len_ct = 32 -> o_sel_ct sequence is 0,1,1; no masking applied; o_len_msg = 64; 4 blocks, then o_done.
4. Source stalls 20 cycles in WAIT_SRC, and i_rqst_msg arrives during FETCH -> no extra or dropped block; pending request honoured; o_en_msg exactly 1 cycle after i_data_valid.
5. i_start pulsed mid-message, then i_rstn asserted mid-fetch -> the i_start is ignored; on reset all outputs are 0 immediately; the next i_start runs cleanly.

Source files
------------

// File: rtl/p_mac_fmt.sv
// p_mac_fmt: AEAD MAC-data formatter feeding a Poly1305 tag engine.
// Fetches AAD then ciphertext 128-bit words from the data buffer, zero-pads
// the last word of each stream to a 16-byte boundary, appends the lengths
// block {len_ct, len_aad} and hands every block to the engine through its
// start / request / enable handshake.
//
// Ports:
//   i_clk, i_rstn        clock (rising edge), asynchronous active-low reset
//   i_start              one-cycle pulse: begin a message, samples the lengths
//   i_len_aad, i_len_ct  AAD / ciphertext byte lengths (0..2^38)
//   o_rqst_data          one-cycle pulse: fetch the next source word
//   o_sel_ct             stream being fetched (0 = AAD, 1 = ciphertext)
//   i_data_valid, i_data source word strobe and little-endian payload
//   i_rqst_msg           engine asks for the next block
//   o_start, o_en_msg    first-block / subsequent-block strobes
//   o_msg                block payload
//   o_len_msg            total MAC length in bytes (multiple of 16)
//   o_busy, o_done       message in progress / one-cycle completion pulse
module p_mac_fmt #(
  parameter int LEN_W = 64
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len_aad,
  input  logic [LEN_W-1:0] i_len_ct,
  output logic             o_rqst_data,
  output logic             o_sel_ct,
  input  logic             i_data_valid,
  input  logic [127:0]     i_data,
  input  logic             i_rqst_msg,
  output logic             o_start,
  output logic             o_en_msg,
  output logic [127:0]     o_msg,
  output logic [64:0]      o_len_msg,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CNT_W = 35;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_SRC, EMIT, WAIT_RQST, LENBLK, DONE
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len_aad;
  logic [LEN_W-1:0] len_ct;
  logic [CNT_W-1:0] na_left;
  logic [CNT_W-1:0] nc_left;
  logic             first;
  logic             pend;

  // ceil(len/16) over the legal 0..2^38 range
  function automatic logic [CNT_W-1:0] blocks_of(input logic [LEN_W-1:0] len);
    return len[CNT_W+3:4] + {{(CNT_W-1){1'b0}}, |len[3:0]};
  endfunction

  // Zero bytes r..15 of the final word of a stream with a partial tail
  function automatic logic [127:0] pad_word(input logic [127:0] w,
                                            input logic [3:0]   r,
                                            input logic         last);
    logic [127:0] m;
    m = '1;
    if (last && (r != 4'd0)) begin
      for (int b = 0; b < 16; b++) begin
        if (4'(b) >= r) m[8*b +: 8] = 8'h00;
      end
    end
    return w & m;
  endfunction

  logic [CNT_W-1:0] na_new;
  logic [CNT_W-1:0] nc_new;
  logic [64:0]      len_new;
  logic             cur_last;
  logic [3:0]       cur_rem;

  assign na_new   = blocks_of(i_len_aad);
  assign nc_new   = blocks_of(i_len_ct);
  // 16 * (na + nc + 1), carried in 65 bits so it cannot wrap
  assign len_new  = {({26'd0, na_new} + {26'd0, nc_new} + 61'd1), 4'd0};
  assign cur_last = o_sel_ct ? (nc_left == CNT_ONE) : (na_left == CNT_ONE);
  assign cur_rem  = o_sel_ct ? len_ct[3:0] : len_aad[3:0];

  // Outputs are registered and set on the transition into the state in
  // which they are visible, so each strobe is high for exactly that state.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= IDLE;
      len_aad     <= '0;
      len_ct      <= '0;
      na_left     <= '0;
      nc_left     <= '0;
      first       <= 1'b0;
      pend        <= 1'b0;
      o_rqst_data <= 1'b0;
      o_sel_ct    <= 1'b0;
      o_start     <= 1'b0;
      o_en_msg    <= 1'b0;
      o_msg       <= '0;
      o_len_msg   <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_rqst_data <= 1'b0;
      o_start     <= 1'b0;
      o_en_msg    <= 1'b0;
      o_done      <= 1'b0;

      // An early engine request is remembered; a second one is dropped.
      if (i_rqst_msg && (state != IDLE) && (state != WAIT_RQST)) pend <= 1'b1;

      case (state)
        IDLE: begin
          if (i_start) begin
            len_aad   <= i_len_aad;
            len_ct    <= i_len_ct;
            na_left   <= na_new;
            nc_left   <= nc_new;
            o_len_msg <= len_new;
            o_busy    <= 1'b1;
            pend      <= 1'b0;
            if ((na_new == '0) && (nc_new == '0)) begin
              o_msg   <= {i_len_ct, i_len_aad};
              o_start <= 1'b1;
              first   <= 1'b0;
              state   <= LENBLK;
            end else begin
              first       <= 1'b1;
              o_rqst_data <= 1'b1;
              o_sel_ct    <= (na_new == '0);
              state       <= FETCH;
            end
          end
        end
        FETCH: state <= WAIT_SRC;
        WAIT_SRC: begin
          if (i_data_valid) begin
            o_msg    <= pad_word(i_data, cur_rem, cur_last);
            o_start  <= first;
            o_en_msg <= !first;
            first    <= 1'b0;
            if (o_sel_ct) nc_left <= nc_left - CNT_ONE;
            else          na_left <= na_left - CNT_ONE;
            state    <= EMIT;
          end
        end
        EMIT: state <= WAIT_RQST;
        WAIT_RQST: begin
          if (i_rqst_msg || pend) begin
            pend <= 1'b0;
            if ((na_left != '0) || (nc_left != '0)) begin
              o_rqst_data <= 1'b1;
              o_sel_ct    <= (na_left == '0);
              state       <= FETCH;
            end else begin
              o_msg    <= {len_ct, len_aad};
              o_en_msg <= 1'b1;
              state    <= LENBLK;
            end
          end
        end
        LENBLK: begin
          o_done <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          o_busy <= 1'b0;
          pend   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
